mmio_gpio_bank: RTL and testbench
=================================

Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank on the MCU data-memory bus. It replaces fixed LED/LCD/GPIO latch registers with NPORTS generic 8-bit ports.
- Each port provides an output latch, a direction register, a synchronised input, per-edge interrupt enables and sticky edge-pending flags.
- Sits beside the mcu instance in the board top. It decodes dmem_addr against BASE_ADDR and supplies registered read data to the top-level rdata mux.

Parameters:
- ADDR_W, 10: dmem byte-address width.
- BASE_ADDR, 'h080: first byte address of the window; must be a multiple of 8*NPORTS.
- NPORTS, 2: number of 8-bit ports, 1..8.
- SYNC_STAGES, 2: input synchroniser depth, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- dmem_addr  in  ADDR_W  byte address
- dmem_wen  in  1  write strobe
- dmem_byt  in  1  1 = byte access, 0 = 16-bit word access
- dmem_wdata  in  16  write data
- dmem_rdata  out  16  read data, valid one cycle after address
- dmem_hit  out  1  registered: previous-cycle address was inside the window
- gpio_in  in  8*NPORTS  asynchronous pad inputs
- gpio_out  out  8*NPORTS  output latches
- gpio_oe  out  8*NPORTS  output enables (1 = drive)
- irq  out  1  registered OR of all pending bits

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset, all of the following are 0: OUT, DIR, IE_R, IE_F, PEND, synchroniser flops, previous-input register, dmem_rdata, dmem_hit, irq.
- Window: BASE_ADDR .. BASE_ADDR+8*NPORTS-1. Port p uses offset o = addr - BASE_ADDR - 8p:
  - o=0 OUT (rw)
  - o=1 DIR (rw)
  - o=2 IN (read-only; writes ignored)
  - o=3 reserved (reads 0)
  - o=4 IE_R (rw)
  - o=5 IE_F (rw)
  - o=6 PEND (write-1-to-clear)
  - o=7 reserved (reads 0)
- Write lanes:
  - Byte write to an even address takes wdata[7:0].
  - Byte write to an odd address takes wdata[15:8].
  - Word write to an even address writes the even byte from wdata[7:0] and the odd byte from wdata[15:8].
  - Word write to an odd address is ignored entirely.
- Writes outside the window are ignored. Writes take effect at the clock edge where dmem_wen=1.
- gpio_out = OUT and gpio_oe = DIR, driven directly from the registers: change one cycle after the write edge.
- Input path:
  - gpio_in passes through SYNC_STAGES flops to produce IN.
  - A previous-value register samples IN every cycle.
  - rise = IN & ~prev; fall = ~IN & prev.
- Pending:
  - PEND_next = (PEND & ~clr) | (rise & IE_R) | (fall & IE_F).
  - Set wins over a simultaneous write-1-clear on the same bit.
- irq is registered one cycle after any PEND bit is 1. It falls one cycle after PEND becomes all-zero.
- Read:
  - addr_d (dmem_addr registered every cycle) selects the 16-bit word {byte[addr_d|1], byte[addr_d&~1]}, so the least-significant address bit is ignored on read.
  - dmem_rdata and dmem_hit are registered from dmem_addr, giving 1-cycle latency.
  - Out-of-window read: dmem_rdata=0, dmem_hit=0.
  - A read of PEND returns the value before any same-cycle clear.
- A write and a read to the same register in the same cycle: the read returns the pre-write value.
- Latency from a pad edge to PEND set is SYNC_STAGES+1 cycles; irq follows one cycle later.
- Reset asserted mid-operation clears everything immediately. The first cycles after reset release cannot generate spurious edges because the synchroniser and prev registers are both 0.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset localparams OFS_OUT=0, OFS_DIR=1, OFS_IN=2, OFS_IER=4, OFS_IEF=5, OFS_PEND=6;
  - PORT_STRIDE=8.
- Natural sub-module: gpio_port (one 8-bit port), containing:
  - OUT/DIR/IE/PEND registers;
  - the synchroniser and edge detector;
  - byte write-enable inputs;
  - an 8-register read-out.
- mmio_gpio_bank instantiates gpio_port NPORTS times via generate, and does the address decode, lane steering, read mux and irq OR.

Test Plan:
1. Word write 0xA55A to BASE+0 (p0 OUT/DIR) -> next cycle gpio_out[7:0]=0x5A, gpio_oe[7:0]=0xA5; read BASE+1 returns 0xA55A one cycle later with dmem_hit=1.
2. Byte write wdata=0x3C00 to BASE+9 (p1 DIR) -> gpio_oe[15:8]=0x3C, p1 OUT unchanged; word write to BASE+1 -> no register changes.
3. IE_R(p0)=0x01; drive gpio_in[0] 0→1 -> PEND(p0)=0x01 after 3 cycles, irq=1 one cycle later; byte write 0x01 to BASE+6 -> PEND=0 and irq=0 one cycle after PEND clears. Repeat with IE_F and a falling edge.
4. Same-cycle falling edge on bit 2 (IE_F=0x04) and write-1-clear of 0x04 to PEND -> PEND bit 2 remains 1.
5. Read addresses BASE-2 and BASE+8*NPORTS -> dmem_rdata=0, dmem_hit=0; writes there leave all registers unchanged.
6. With OUT=0xFF and PEND nonzero, assert rst asynchronously between clock edges -> gpio_out, gpio_oe, irq and dmem_rdata are 0 immediately; after release, holding gpio_in high from reset does not set PEND when IE_R=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank.
// Holds the per-port register offsets, the port address stride and the
// byte write-lane helper shared by the bank decoder.
package gpio_pkg;

  localparam logic [2:0] OFS_OUT  = 3'd0;
  localparam logic [2:0] OFS_DIR  = 3'd1;
  localparam logic [2:0] OFS_IN   = 3'd2;
  localparam logic [2:0] OFS_IER  = 3'd4;
  localparam logic [2:0] OFS_IEF  = 3'd5;
  localparam logic [2:0] OFS_PEND = 3'd6;

  localparam int PORT_STRIDE = 8;

  // Register write enables inside one port for a bus write at offset ofs.
  // Byte: only the addressed register. Word at an even offset: the
  // even/odd register pair. Word at an odd offset: nothing.
  function automatic logic [7:0] lane_we(input logic [2:0] ofs, input logic byt);
    logic [7:0] we;
    we = '0;
    if (byt)          we = 8'd1 << ofs;
    else if (!ofs[0]) we = 8'd3 << ofs;
    return we;
  endfunction

endpackage

// File: rtl/gpio_port.sv
// One 8-bit GPIO port: output latch, direction, synchronised input,
// rise/fall interrupt enables and sticky edge-pending flags.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   we[7:0]       per-register write enable (index = register offset)
//   wdata[15:0]   bus write data; even registers take [7:0], odd take [15:8]
//   pad_in[7:0]   asynchronous pad inputs
//   rd_word[1:0]  word index within the port (offset bits [2:1])
//   rd_data[15:0] combinational {odd register, even register} of that word
//   out_q, dir_q  output latch and output enable
//   pend_any      OR of the pending flags
module gpio_port
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  we,
  input  logic [15:0] wdata,
  input  logic [7:0]  pad_in,
  input  logic [1:0]  rd_word,
  output logic [15:0] rd_data,
  output logic [7:0]  out_q,
  output logic [7:0]  dir_q,
  output logic        pend_any
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] in_s, prev_q, ier_q, ief_q, pend_q;
  logic [7:0] rise, fall, clr, pend_nxt;
  logic [7:0][7:0] rmap;

  assign in_s = sync_q[SYNC_STAGES-1];
  assign rise = in_s & ~prev_q;
  assign fall = ~in_s & prev_q;
  assign clr  = we[OFS_PEND] ? wdata[7:0] : 8'h00;
  // Set terms are ORed after the clear so a new edge survives a same-cycle W1C.
  assign pend_nxt = (pend_q & ~clr) | (rise & ier_q) | (fall & ief_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      out_q  <= '0;
      dir_q  <= '0;
      ier_q  <= '0;
      ief_q  <= '0;
      pend_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      prev_q <= in_s;
      pend_q <= pend_nxt;
      if (we[OFS_OUT]) out_q <= wdata[7:0];
      if (we[OFS_DIR]) dir_q <= wdata[15:8];
      if (we[OFS_IER]) ier_q <= wdata[7:0];
      if (we[OFS_IEF]) ief_q <= wdata[15:8];
    end
  end

  always_comb begin
    rmap           = '0;
    rmap[OFS_OUT]  = out_q;
    rmap[OFS_DIR]  = dir_q;
    rmap[OFS_IN]   = in_s;
    rmap[OFS_IER]  = ier_q;
    rmap[OFS_IEF]  = ief_q;
    rmap[OFS_PEND] = pend_q;
  end

  assign rd_data  = {rmap[{rd_word, 1'b1}], rmap[{rd_word, 1'b0}]};
  assign pend_any = |pend_q;

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped bank of NPORTS 8-bit GPIO ports on the MCU data bus.
// Decodes dmem_addr against the window BASE_ADDR..BASE_ADDR+8*NPORTS-1,
// steers write lanes to the addressed port and returns registered read data.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   dmem_addr    byte address        dmem_wen   write strobe
//   dmem_byt     1 = byte, 0 = word  dmem_wdata write data
//   dmem_rdata   read data, one cycle after the address
//   dmem_hit     previous-cycle address was inside the window
//   gpio_in      pad inputs (asynchronous)
//   gpio_out     output latches      gpio_oe    output enables
//   irq          registered OR of all pending flags
module mmio_gpio_bank
  import gpio_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int unsigned BASE_ADDR   = 'h080,
  parameter int          NPORTS      = 2,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     dmem_addr,
  input  logic                  dmem_wen,
  input  logic                  dmem_byt,
  input  logic [15:0]           dmem_wdata,
  output logic [15:0]           dmem_rdata,
  output logic                  dmem_hit,
  input  logic [8*NPORTS-1:0]   gpio_in,
  output logic [8*NPORTS-1:0]   gpio_out,
  output logic [8*NPORTS-1:0]   gpio_oe,
  output logic                  irq
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int LW = PW + 3;

  logic [ADDR_W:0]  addr_x;
  logic             in_win;
  logic [LW-1:0]    offs;
  logic [PW-1:0]    port_sel;
  logic [2:0]       reg_ofs;
  logic [7:0]       lane;

  logic [NPORTS-1:0][15:0] rd_words;
  logic [NPORTS-1:0][7:0]  out_arr, oe_arr, pad_arr;
  logic [NPORTS-1:0]       pend_any;

  assign addr_x = {1'b0, dmem_addr};
  assign in_win = (addr_x >= (ADDR_W+1)'(BASE_ADDR)) &&
                  (addr_x <  (ADDR_W+1)'(BASE_ADDR + PORT_STRIDE*NPORTS));

  // Low bits of a difference depend only on the low bits of the operands,
  // so a narrow subtract yields the port index and register offset.
  assign offs     = dmem_addr[LW-1:0] - LW'(BASE_ADDR);
  assign port_sel = offs[LW-1:3];
  assign reg_ofs  = offs[2:0];
  assign lane     = lane_we(reg_ofs, dmem_byt);

  assign pad_arr  = gpio_in;
  assign gpio_out = out_arr;
  assign gpio_oe  = oe_arr;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [7:0] we_p;
    assign we_p = (dmem_wen && in_win && port_sel == PW'(p)) ? lane : 8'h00;

    gpio_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
      .clk      (clk),
      .rst      (rst),
      .we       (we_p),
      .wdata    (dmem_wdata),
      .pad_in   (pad_arr[p]),
      .rd_word  (reg_ofs[2:1]),
      .rd_data  (rd_words[p]),
      .out_q    (out_arr[p]),
      .dir_q    (oe_arr[p]),
      .pend_any (pend_any[p])
    );
  end

  // Read data is captured from the current register contents, so a same-cycle
  // write or W1C is not yet visible in the returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_rdata <= '0;
      dmem_hit   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      dmem_rdata <= in_win ? rd_words[port_sel] : 16'h0000;
      dmem_hit   <= in_win;
      irq        <= |pend_any;
    end
  end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
module tb_mmio_gpio_bank;

  localparam int ADDR_W = 10;
  localparam int BASE   = 'h080;
  localparam int NP     = 2;

  logic              clk, rst;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_wen, dmem_byt;
  logic [15:0]       dmem_wdata, dmem_rdata;
  logic              dmem_hit, irq;
  logic [8*NP-1:0]   gpio_in, gpio_out, gpio_oe;

  mmio_gpio_bank #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NPORTS(NP), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_byt(dmem_byt), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_hit(dmem_hit), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] sb[$];
  string       sb_name[$];
  logic        rd_req, rd_req_d;

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: a read issued in the previous cycle presents its data now.
  always @(negedge clk) begin
    if (rd_req_d) begin
      logic [16:0] e;
      string nm;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rdata=%h hit=%b with empty scoreboard", dmem_rdata, dmem_hit);
      end else begin
        e  = sb.pop_front();
        nm = sb_name.pop_front();
        if ({dmem_rdata, dmem_hit} !== e) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h hit=%b expected rdata=%h hit=%b",
                   nm, dmem_rdata, dmem_hit, e[16:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    dmem_wen = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic bus_wr(input int a, input logic [15:0] d, input logic byt);
    @(negedge clk);
    dmem_addr  = ADDR_W'(a);
    dmem_wdata = d;
    dmem_byt   = byt;
    dmem_wen   = 1'b1;
    rd_req     = 1'b0;
  endtask

  task automatic bus_rd(input string nm, input int a, input logic [15:0] exp, input logic hit);
    @(negedge clk);
    dmem_addr = ADDR_W'(a);
    dmem_wen  = 1'b0;
    rd_req    = 1'b1;
    sb.push_back({exp, hit});
    sb_name.push_back(nm);
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0;
    dmem_addr = '0; dmem_wen = 1'b0; dmem_byt = 1'b0; dmem_wdata = '0; gpio_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_oe",  32'(gpio_oe),  32'h0);
    chk("rst_irq", 32'(irq),      32'h0);
    bus_rd("rst_rd_p0", BASE + 0, 16'h0000, 1'b1);
    bus_rd("rst_rd_p1pend", BASE + 14, 16'h0000, 1'b1);

    // 1: word write OUT/DIR of port 0
    bus_wr(BASE + 0, 16'hA55A, 1'b0);
    idle();
    chk("t1_out", 32'(gpio_out[7:0]), 32'h5A);
    chk("t1_oe",  32'(gpio_oe[7:0]),  32'hA5);
    bus_rd("t1_rd_odd", BASE + 1, 16'hA55A, 1'b1);

    // 2: byte write to odd address, ignored odd word write
    bus_wr(BASE + 9, 16'h3C00, 1'b1);
    idle();
    chk("t2_oe1",  32'(gpio_oe[15:8]),  32'h3C);
    chk("t2_out1", 32'(gpio_out[15:8]), 32'h00);
    bus_wr(BASE + 1, 16'hFFFF, 1'b0);
    idle();
    chk("t2_oddword_out", 32'(gpio_out), 32'h005A);
    chk("t2_oddword_oe",  32'(gpio_oe),  32'h3CA5);
    bus_rd("t2_rd_p1", BASE + 8, 16'h3C00, 1'b1);
    bus_rd("t2_rd_in", BASE + 2, 16'h0000, 1'b1);

    // 3: rising edge interrupt, then clear
    bus_wr(BASE + 4, 16'h0001, 1'b1);
    idle();
    gpio_in = 16'h0001;
    idle(); idle();
    chk("t3_irq_e2", 32'(irq), 32'h0);
    idle();
    chk("t3_irq_e3", 32'(irq), 32'h0);
    bus_rd("t3_pend_set", BASE + 6, 16'h0001, 1'b1);
    bus_wr(BASE + 6, 16'h0001, 1'b1);
    chk("t3_irq_e4", 32'(irq), 32'h1);
    idle();
    chk("t3_irq_hold", 32'(irq), 32'h1);
    idle();
    chk("t3_irq_clr", 32'(irq), 32'h0);
    bus_rd("t3_pend_clr", BASE + 6, 16'h0000, 1'b1);
    bus_rd("t3_rd_in", BASE + 2, 16'h0001, 1'b1);
    // falling edge: word write IE_R=00, IE_F=01
    bus_wr(BASE + 4, 16'h0100, 1'b0);
    idle();
    gpio_in = 16'h0000;
    repeat (5) idle();
    chk("t3f_irq", 32'(irq), 32'h1);
    bus_rd("t3f_pend", BASE + 6, 16'h0001, 1'b1);
    bus_wr(BASE + 6, 16'h0001, 1'b0);
    idle(); idle();
    chk("t3f_irq_clr", 32'(irq), 32'h0);
    bus_rd("t3f_pend_clr", BASE + 6, 16'h0000, 1'b1);

    // 4: falling edge sets PEND in the same cycle as a W1C of that bit
    bus_wr(BASE + 4, 16'h0400, 1'b0);
    idle();
    gpio_in = 16'h0004;
    repeat (4) idle();
    gpio_in = 16'h0000;
    idle();
    bus_wr(BASE + 6, 16'h0004, 1'b1);
    idle();
    bus_rd("t4_set_wins", BASE + 6, 16'h0004, 1'b1);
    bus_wr(BASE + 6, 16'h0004, 1'b1);
    idle();
    bus_rd("t4_pend_clr", BASE + 6, 16'h0000, 1'b1);

    // 5: out-of-window accesses
    bus_rd("t5_rd_below", BASE - 2, 16'h0000, 1'b0);
    bus_rd("t5_rd_above", BASE + 8*NP, 16'h0000, 1'b0);
    bus_wr(BASE - 2, 16'hFFFF, 1'b0);
    bus_wr(BASE + 8*NP, 16'hFFFF, 1'b0);
    idle();
    chk("t5_out", 32'(gpio_out), 32'h005A);
    chk("t5_oe",  32'(gpio_oe),  32'h3CA5);
    bus_rd("t5_ie_p0", BASE + 4, 16'h0400, 1'b1);

    // 6: asynchronous reset mid-operation
    bus_wr(BASE + 0, 16'h00FF, 1'b1);
    bus_wr(BASE + 4, 16'h0002, 1'b1);
    idle();
    gpio_in = 16'h0002;
    repeat (5) idle();
    chk("t6_irq_pre", 32'(irq), 32'h1);
    bus_rd("t6_rd_pre", BASE + 0, 16'hA5FF, 1'b1);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out",   32'(gpio_out),   32'h0);
    chk("t6_rst_oe",    32'(gpio_oe),    32'h0);
    chk("t6_rst_irq",   32'(irq),        32'h0);
    chk("t6_rst_rdata", 32'(dmem_rdata), 32'h0);
    chk("t6_rst_hit",   32'(dmem_hit),   32'h0);
    gpio_in = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) idle();
    chk("t6_post_irq", 32'(irq), 32'h0);
    bus_rd("t6_post_pend0", BASE + 6, 16'h0000, 1'b1);
    bus_rd("t6_post_pend1", BASE + 14, 16'h0000, 1'b1);
    bus_rd("t6_post_in0", BASE + 2, 16'h00FF, 1'b1);
    bus_rd("t6_post_in1", BASE + 10, 16'h00FF, 1'b1);
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d outstanding reads expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
